// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave.
//   spi_state_e       - slave FSM states (IDLE: cs_n high, ACTIVE: cs_n low)
//   SPI_DATA_W        - frame width in bits
//   SPI_UNDERRUN_FILL - default byte shifted out when no TX byte is queued
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam logic [SPI_DATA_W-1:0] SPI_UNDERRUN_FILL = 8'hFF;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer followed by one edge-detect register.
// Ports:
//   clk_i, rst_ni  - system clock, async active-low reset
//   d_i            - asynchronous input
//   rise_o, fall_o - single-cycle pulses on the synchronized rising/falling edge
// Parameters:
//   STAGES  - synchronizer depth (>= 2)
//   RST_VAL - idle level loaded into every flop on reset, so that
//             leaving reset never looks like an edge
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign s      = sync_q[STAGES-1];
    assign rise_o = s & ~prev_q;
    assign fall_o = ~s & prev_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, 8-bit MSB-first frames, back-to-back bytes
// allowed within one cs_n assertion. All SPI inputs are oversampled on clk.
// Ports:
//   clk_i, rst_ni          - system clock, async active-low reset
//   sclk_i, cs_ni, mosi_i  - SPI bus from the master (asynchronous)
//   miso_o, miso_oe_o      - slave data out and its output enable
//   tx_data_i/tx_valid_i/tx_ready_o - one-deep TX holding register
//   rx_data_o/rx_valid_o   - last received byte and its update pulse
//   busy_o                 - frame in progress (ACTIVE)
//   tx_underrun_o          - pulse: fill byte loaded instead of a queued byte
//   frame_err_o            - pulse: cs_n rose in the middle of a byte
module spi_slave
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES   = 2,
    parameter logic [SPI_DATA_W-1:0] UNDERRUN_FILL = SPI_UNDERRUN_FILL
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sclk_i,
    input  logic                  cs_ni,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [SPI_DATA_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [SPI_DATA_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  tx_underrun_o,
    output logic                  frame_err_o
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i (clk_i), .rst_ni(rst_ni), .d_i(sclk_i),
        .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i (clk_i), .rst_ni(rst_ni), .d_i(cs_ni),
        .rise_o(cs_rise), .fall_o(cs_fall)
    );

    // mosi only needs a level; same depth keeps it aligned with sclk edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mosi_q <= '0;
        else         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    spi_state_e              state_q;
    logic [2:0]              bit_cnt_q;
    logic [SPI_DATA_W-2:0]   rx_sh_q;   // bits received so far; LSB arrives separately
    logic [SPI_DATA_W-1:0]   tx_sh_q;
    logic [SPI_DATA_W-1:0]   hold_q;
    logic                    tx_ready_q;
    logic [SPI_DATA_W-1:0]   rx_data_q;
    logic                    rx_valid_q, tx_underrun_q, frame_err_q;
    logic [SPI_DATA_W-1:0]   load_byte;

    // Reload source uses the registered holding state, so a byte accepted in
    // the reload cycle itself is kept for the following byte.
    assign load_byte = tx_ready_q ? UNDERRUN_FILL : hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_sh_q       <= '0;
            tx_sh_q       <= '0;
            hold_q        <= '0;
            tx_ready_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;

            if (tx_valid_i && tx_ready_q) begin
                hold_q     <= tx_data_i;
                tx_ready_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ACTIVE;
                        bit_cnt_q <= '0;
                        tx_sh_q   <= load_byte;
                        if (tx_ready_q) tx_underrun_q <= 1'b1;
                        else            tx_ready_q    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // cs_n rise wins over a coincident sclk edge
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                        if (bit_cnt_q != 3'd0) frame_err_q <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_sh_q   <= {rx_sh_q[SPI_DATA_W-3:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= {rx_sh_q, mosi_s};
                            rx_valid_q <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            tx_sh_q <= tx_sh_q << 1;
                        end else begin
                            tx_sh_q <= load_byte;
                            if (tx_ready_q) tx_underrun_q <= 1'b1;
                            else            tx_ready_q    <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o        = (state_q == ACTIVE);
    assign miso_oe_o     = (state_q == ACTIVE);
    assign miso_o        = (state_q == ACTIVE) & tx_sh_q[SPI_DATA_W-1];
    assign tx_ready_o    = tx_ready_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = tx_underrun_q;
    assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus randomized frames, checked
// against a transaction-level model (a byte queue for the TX side, the
// master's own data for the RX side).
module tb_spi_slave;

    localparam int HALF = 4;   // sclk half period in clk cycles

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, frame_err;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2), .UNDERRUN_FILL(8'hFF)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_ni(cs_n), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
        .tx_underrun_o(tx_underrun), .frame_err_o(frame_err)
    );

    int vectors = 0, miscompares = 0;

    // pulse monitor: every rx_valid cycle logs one byte, pulses are counted
    logic [7:0] rx_log [256];
    int rx_n = 0, urun_n = 0, ferr_n = 0;
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin rx_log[rx_n % 256] = rx_data; rx_n++; end
        if (tx_underrun === 1'b1) urun_n++;
        if (frame_err === 1'b1) ferr_n++;
    end

    logic [7:0] m_out [4];   // bytes the master sends
    logic [7:0] m_in  [4];   // bytes the master samples on miso
    logic [7:0] txq [$];     // bytes queued to the slave, not yet transmitted

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic queue_tx(input logic [7:0] b);
        tx_data = b; tx_valid = 1'b1;
        wait_n(1);
        tx_valid = 1'b0;
        txq.push_back(b);
    endtask

    // Mode-0 master. The last sclk fall coincides with the cs_n rise.
    // inject: present tx_valid exactly in the reload cycle after byte 0.
    // rst_abort: pull rst_n low instead of ending the frame.
    task automatic xfer(input int nbits, input bit inject, input logic [7:0] inj,
                        input bit rst_abort);
        cs_n = 1'b0; mosi = m_out[0][7];
        wait_n(HALF + 2);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            m_in[i / 8][7 - (i % 8)] = miso;
            wait_n(HALF);
            if (i == nbits - 1) begin
                if (rst_abort) begin rst_n = 1'b0; return; end
                sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
                wait_n(HALF + 4);
            end else begin
                sclk = 1'b0; mosi = m_out[(i + 1) / 8][7 - ((i + 1) % 8)];
                if (inject && i == 7) begin
                    // fall detected after 2 sync edges; reload on the 3rd edge
                    wait_n(2);
                    tx_data = inj; tx_valid = 1'b1;
                    wait_n(1);
                    tx_valid = 1'b0;
                    wait_n(HALF - 3);
                end else begin
                    wait_n(HALF);
                end
            end
        end
    endtask

    // Whole-byte frame; inject is only meaningful with nbytes == 2.
    task automatic run_frame(input int nbytes, input bit inject, input logic [7:0] inj,
                             input string tag);
        logic [7:0] exp_b [4];
        int eu, u0, r0, f0;
        eu = 0;
        for (int k = 0; k < nbytes; k++) begin
            if (txq.size() != 0) exp_b[k] = txq.pop_front();
            else begin exp_b[k] = 8'hFF; eu++; end
        end
        if (inject) txq.push_back(inj);
        u0 = urun_n; r0 = rx_n; f0 = ferr_n;
        xfer(nbytes * 8, inject, inj, 1'b0);
        for (int k = 0; k < nbytes; k++) begin
            chk({tag, "_miso"}, m_in[k], exp_b[k]);
            chk({tag, "_rxlog"}, rx_log[(r0 + k) % 256], m_out[k]);
        end
        chk({tag, "_rx_cnt"}, rx_n - r0, nbytes);
        chk({tag, "_urun_cnt"}, urun_n - u0, eu);
        chk({tag, "_ferr_cnt"}, ferr_n - f0, 0);
        chk({tag, "_rx_data"}, rx_data, m_out[nbytes - 1]);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int r0, f0, nb;

        // reset state
        wait_n(2);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_pulses", {rx_valid, tx_underrun, frame_err, miso}, 4'b0);
        rst_n = 1'b1;
        wait_n(4);

        // single byte exchange
        queue_tx(8'hA5);
        chk("q_tx_ready_low", tx_ready, 1'b0);
        m_out[0] = 8'h3C;
        run_frame(1, 1'b0, 8'h00, "basic");
        chk("basic_tx_ready", tx_ready, 1'b1);

        // two bytes in one frame, second underruns
        queue_tx(8'h11);
        m_out[0] = 8'hF0; m_out[1] = 8'h0F;
        run_frame(2, 1'b0, 8'h00, "two");

        // partial frame
        r0 = rx_n; f0 = ferr_n;
        m_out[0] = 8'hE7;
        void'(txq.size());
        xfer(5, 1'b0, 8'h00, 1'b0);
        chk("part_ferr_cnt", ferr_n - f0, 1);
        chk("part_rx_cnt", rx_n - r0, 0);
        chk("part_rx_data", rx_data, 8'h0F);
        m_out[0] = 8'h5A;
        run_frame(1, 1'b0, 8'h00, "after_part");

        // reset mid-frame
        r0 = rx_n; f0 = ferr_n;
        m_out[0] = 8'h96;
        xfer(4, 1'b0, 8'h00, 1'b1);
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_miso_oe", miso_oe, 1'b0);
        chk("arst_miso", miso, 1'b0);
        chk("arst_rx_data", rx_data, 8'h00);
        chk("arst_tx_ready", tx_ready, 1'b1);
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(4);
        chk("arst_no_pulses", {rx_n - r0, ferr_n - f0}, 64'd0);
        txq.delete();
        m_out[0] = 8'hC3;
        run_frame(1, 1'b0, 8'h00, "after_rst");

        // tx_valid in the reload cycle: underrun now, byte goes out next
        queue_tx(8'h42);
        m_out[0] = 8'h81; m_out[1] = 8'h7E;
        run_frame(2, 1'b1, 8'h77, "inject");
        chk("inject_tx_ready", tx_ready, 1'b0);
        m_out[0] = 8'h24;
        run_frame(1, 1'b0, 8'h00, "inject_next");

        // sclk toggling with cs_n high is ignored
        r0 = rx_n;
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            sclk = 1'b1; wait_n(HALF);
            chk("idle_oe", miso_oe, 1'b0);
            sclk = 1'b0; wait_n(HALF);
            chk("idle_busy", busy, 1'b0);
        end
        wait_n(4);
        chk("idle_rx_cnt", rx_n - r0, 0);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(1) == 1) queue_tx(8'($urandom));
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) m_out[k] = 8'($urandom);
            run_frame(nb, 1'b0, 8'h00, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
